// File: rtl/inst_rom_pkg.sv
// Shared types and constants for the instruction ROM and its loader.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package inst_rom_pkg;

    localparam int InstBusWidth = 32;
    localparam int ByteWidth    = 8;

    localparam logic [InstBusWidth-1:0] ZeroWord = 32'h0000_0000;

    // Loader/fetch state: IDLE after reset, LOAD while bytes stream in,
    // READY once an image is resident and the core may run.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_e;

endpackage

// File: rtl/inst_rom_if.sv
// Fetch port plus byte-serial loader port of the instruction ROM.
// Latency: fetch data is combinational from rom_ce_i/rom_addr_i.
// Backpressure: loader bytes move only when ld_valid_i && ld_ready_o.
interface inst_rom_if
    import inst_rom_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) ();

    logic                    rom_ce_i;
    logic [InstBusWidth-1:0] rom_addr_i;
    logic [InstBusWidth-1:0] rom_data_o;

    logic                    ld_start_i;
    logic                    ld_valid_i;
    logic [ByteWidth-1:0]    ld_byte_i;
    logic                    ld_last_i;
    logic                    ld_ready_o;
    logic                    ld_done_o;
    logic                    ld_err_o;
    logic [DEPTH_LOG2:0]     word_count_o;
    logic                    cpu_hold_o;

    // The ROM side.
    modport slave (
        input  rom_ce_i, rom_addr_i,
        output rom_data_o,
        input  ld_start_i, ld_valid_i, ld_byte_i, ld_last_i,
        output ld_ready_o, ld_done_o, ld_err_o, word_count_o, cpu_hold_o
    );

    // The core/loader side.
    modport master (
        output rom_ce_i, rom_addr_i,
        input  rom_data_o,
        output ld_start_i, ld_valid_i, ld_byte_i, ld_last_i,
        input  ld_ready_o, ld_done_o, ld_err_o, word_count_o, cpu_hold_o
    );

endinterface

// File: rtl/inst_rom_word_packer.sv
// Packs big-endian loader bytes into 32-bit words, zero-padding a final partial word.
// Latency: write strobe is combinational with the 4th (or last) accepted byte.
// Backpressure: none; the caller qualifies byte_vld_i with its own ready.
module rom_word_packer
    import inst_rom_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    byte_vld_i,
    input  logic [ByteWidth-1:0]    byte_dat_i,
    input  logic                    last_i,
    output logic                    wr_vld_o,
    output logic [InstBusWidth-1:0] wr_dat_o
);

    logic [1:0]              bcnt_q, bcnt_d;
    logic [InstBusWidth-1:0] shift_q, shift_d;
    logic [InstBusWidth-1:0] merged;

    // Drop the incoming byte into its big-endian lane; unfilled low lanes stay zero.
    always_comb begin
        merged = ZeroWord;
        case (bcnt_q)
            2'd0:    merged = {byte_dat_i, 24'h0};
            2'd1:    merged = {shift_q[31:24], byte_dat_i, 16'h0};
            2'd2:    merged = {shift_q[31:16], byte_dat_i, 8'h0};
            default: merged = {shift_q[31:8], byte_dat_i};
        endcase
    end

    assign wr_vld_o = byte_vld_i && !clr_i && ((bcnt_q == 2'd3) || last_i);
    assign wr_dat_o = merged;

    // Next lane count / partial word; a write or a restart empties the register.
    always_comb begin
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        if (clr_i) begin
            bcnt_d  = 2'd0;
            shift_d = ZeroWord;
        end else if (byte_vld_i) begin
            if (wr_vld_o) begin
                bcnt_d  = 2'd0;
                shift_d = ZeroWord;
            end else begin
                bcnt_d  = bcnt_q + 2'd1;
                shift_d = merged;
            end
        end
    end

    // Partial-word state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bcnt_q  <= 2'd0;
            shift_q <= ZeroWord;
        end else begin
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/inst_rom.sv
// Instruction ROM: zero-latency fetch reads, contents loaded over a byte-serial port.
// Latency: fetch 0 cycles; READY entered on the edge after the last loader byte.
// Backpressure: ld_ready_o only in LOAD; the core is held in reset until READY.
module inst_rom
    import inst_rom_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    inst_rom_if.slave   rom_bus
);

    localparam int Depth = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FullCount = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] LastIdx   = {1'b0, {DEPTH_LOG2{1'b1}}};
    localparam logic [DEPTH_LOG2:0] PtrOne    = {{DEPTH_LOG2{1'b0}}, 1'b1};

    state_e                  state_q, state_d;
    logic [DEPTH_LOG2:0]     wptr_q, wptr_d;
    logic [DEPTH_LOG2:0]     wcnt_q, wcnt_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;

    logic                    byte_acc;
    logic                    pk_wr_vld;
    logic [InstBusWidth-1:0] pk_wr_dat;

    logic [InstBusWidth-1:0] mem [Depth];
    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic                    rd_hit;
    logic                    unused_addr;

    // A start in the same cycle as a byte wins, so that byte is never accepted.
    assign byte_acc = (state_q == ST_LOAD) && rom_bus.ld_valid_i && !rom_bus.ld_start_i;

    rom_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (rom_bus.ld_start_i),
        .byte_vld_i (byte_acc),
        .byte_dat_i (rom_bus.ld_byte_i),
        .last_i     (rom_bus.ld_last_i),
        .wr_vld_o   (pk_wr_vld),
        .wr_dat_o   (pk_wr_dat)
    );

    // Load sequencing: advance the write pointer per word, finish on last byte or on a full array.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (pk_wr_vld) begin
                    wptr_d = wptr_q + PtrOne;
                end
                if (byte_acc && rom_bus.ld_last_i) begin
                    state_d = ST_READY;
                    wcnt_d  = wptr_d;
                    done_d  = 1'b1;
                end else if (pk_wr_vld && (wptr_q == LastIdx)) begin
                    // Image is larger than the array: keep what fits and flag it.
                    state_d = ST_READY;
                    wcnt_d  = FullCount;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase
        if (rom_bus.ld_start_i) begin
            state_d = ST_LOAD;
            wptr_d  = '0;
            wcnt_d  = '0;
            err_d   = 1'b0;
            done_d  = 1'b0;
        end
    end

    // Control state register; reset beats a simultaneous start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            wptr_q  <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Word writes into the array; contents survive reset and are hidden by word_count instead.
    always_ff @(posedge clk) begin
        if (rst && pk_wr_vld) begin
            mem[wptr_q[DEPTH_LOG2-1:0]] <= pk_wr_dat;
        end
    end

    assign rd_idx      = rom_bus.rom_addr_i[DEPTH_LOG2+1:2];
    assign unused_addr = ^{rom_bus.rom_addr_i[InstBusWidth-1:DEPTH_LOG2+2],
                           rom_bus.rom_addr_i[1:0]};

    // Only loaded words are visible, and only once READY; everything else fetches NOP.
    always_comb begin
        rd_hit = (state_q == ST_READY) && rom_bus.rom_ce_i &&
                 ({1'b0, rd_idx} < wcnt_q);
        rom_bus.rom_data_o = rd_hit ? mem[rd_idx] : ZeroWord;
    end

    assign rom_bus.ld_ready_o   = (state_q == ST_LOAD);
    assign rom_bus.ld_done_o    = done_q;
    assign rom_bus.ld_err_o     = err_q;
    assign rom_bus.word_count_o = wcnt_q;
    assign rom_bus.cpu_hold_o   = (state_q != ST_READY);

endmodule

// File: tb/tb_inst_rom.sv
module tb_inst_rom;

    logic clk;
    logic rst;

    int total = 0;
    int bad   = 0;

    // Reference image: word list, visible word count and overflow flag.
    logic [31:0] ref_words [1024];
    int          ref_cnt;
    logic        ref_err;

    inst_rom_if #(.DEPTH_LOG2(10)) bus_a ();
    inst_rom_if #(.DEPTH_LOG2(2))  bus_b ();

    inst_rom #(.DEPTH_LOG2(10)) u_dut_a (.clk(clk), .rst(rst), .rom_bus(bus_a));
    inst_rom #(.DEPTH_LOG2(2))  u_dut_b (.clk(clk), .rst(rst), .rom_bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Image built straight from the byte list: 4 bytes per word, MSB first,
    // truncated to the array size, trailing word zero-padded.
    task automatic model_load(input logic [7:0] b[$], input bit last, input int depth);
        int cap  = 4 * depth;
        int n    = b.size();
        int used = (n < cap) ? n : cap;
        for (int i = 0; i < (used + 3) / 4; i++) ref_words[i] = 32'h0;
        for (int i = 0; i < used; i++)
            ref_words[i/4] = ref_words[i/4] | ({24'h0, b[i]} << (8 * (3 - (i % 4))));
        ref_cnt = (used + 3) / 4;
        ref_err = (n > cap) || (n == cap && !last);
    endtask

    task automatic start_a();
        bus_a.ld_start_i = 1'b1;
        tick();
        bus_a.ld_start_i = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] b[$], input bit last);
        for (int i = 0; i < b.size(); i++) begin
            bus_a.ld_valid_i = 1'b1;
            bus_a.ld_byte_i  = b[i];
            bus_a.ld_last_i  = last && (i == b.size() - 1);
            tick();
            bus_a.ld_valid_i = 1'b0;
            bus_a.ld_last_i  = 1'b0;
        end
    endtask

    // One fetch per cycle, checked against the reference image.
    task automatic fetch_a(input logic [31:0] addr, input bit ce, input string tag);
        int          idx;
        logic [31:0] exp;
        tick();
        bus_a.rom_ce_i   = ce;
        bus_a.rom_addr_i = addr;
        #1;
        idx = int'(addr[11:2]);
        exp = (ce && idx < ref_cnt) ? ref_words[idx] : 32'h0;
        check(tag, bus_a.rom_data_o, exp);
    endtask

    initial begin
        logic [7:0]  q [$];
        logic [7:0]  qb [$];
        logic [31:0] addr;
        int          n;

        rst = 1'b0;
        bus_a.rom_ce_i = 1'b0; bus_a.rom_addr_i = '0; bus_a.ld_start_i = 1'b0;
        bus_a.ld_valid_i = 1'b0; bus_a.ld_byte_i = '0; bus_a.ld_last_i = 1'b0;
        bus_b.rom_ce_i = 1'b0; bus_b.rom_addr_i = '0; bus_b.ld_start_i = 1'b0;
        bus_b.ld_valid_i = 1'b0; bus_b.ld_byte_i = '0; bus_b.ld_last_i = 1'b0;
        ref_cnt = 0;
        ref_err = 1'b0;

        // Reset state.
        repeat (2) tick();
        bus_a.rom_ce_i = 1'b1; bus_a.rom_addr_i = 32'h0;
        #1;
        check("rst_data",  bus_a.rom_data_o, 32'h0);
        check("rst_hold",  {31'h0, bus_a.cpu_hold_o}, 32'h1);
        check("rst_wcnt",  {21'h0, bus_a.word_count_o}, 32'h0);
        check("rst_ready", {31'h0, bus_a.ld_ready_o}, 32'h0);
        check("rst_done",  {31'h0, bus_a.ld_done_o}, 32'h0);
        check("rst_err",   {31'h0, bus_a.ld_err_o}, 32'h0);
        check("rst_b_hold", {31'h0, bus_b.cpu_hold_o}, 32'h1);
        check("rst_b_wcnt", {29'h0, bus_b.word_count_o}, 32'h0);
        rst = 1'b1;
        tick();
        check("idle_data", bus_a.rom_data_o, 32'h0);
        check("idle_hold", {31'h0, bus_a.cpu_hold_o}, 32'h1);

        // Two-word image.
        start_a();
        check("load_ready", {31'h0, bus_a.ld_ready_o}, 32'h1);
        check("load_data",  bus_a.rom_data_o, 32'h0);
        bus_a.ld_last_i = 1'b1;
        tick();
        bus_a.ld_last_i = 1'b0;
        check("last_no_valid", {31'h0, bus_a.ld_ready_o}, 32'h1);
        q = '{8'h34, 8'h01, 8'h00, 8'h05, 8'h24, 8'h02, 8'h00, 8'h07};
        send_a(q, 1'b1);
        model_load(q, 1'b1, 1024);
        check("t2_done", {31'h0, bus_a.ld_done_o}, 32'h1);
        check("t2_hold", {31'h0, bus_a.cpu_hold_o}, 32'h0);
        check("t2_wcnt", {21'h0, bus_a.word_count_o}, 32'd2);
        check("t2_ready", {31'h0, bus_a.ld_ready_o}, 32'h0);
        tick();
        check("t2_done_pulse", {31'h0, bus_a.ld_done_o}, 32'h0);
        fetch_a(32'h0, 1'b1, "t2_m0");
        check("t2_a0", bus_a.rom_data_o, 32'h3401_0005);
        fetch_a(32'h4, 1'b1, "t2_m4");
        check("t2_a4", bus_a.rom_data_o, 32'h2402_0007);
        fetch_a(32'h6, 1'b1, "t2_m6");
        check("t2_a6", bus_a.rom_data_o, 32'h2402_0007);
        fetch_a(32'h8, 1'b1, "t2_a8");

        // Partial trailing word, then disabled fetches.
        start_a();
        check("t3_load_data", bus_a.rom_data_o, 32'h0);
        q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send_a(q, 1'b1);
        model_load(q, 1'b1, 1024);
        check("t3_wcnt", {21'h0, bus_a.word_count_o}, 32'd2);
        check("t3_err",  {31'h0, bus_a.ld_err_o}, 32'h0);
        fetch_a(32'h4, 1'b1, "t3_m4");
        check("t3_a4", bus_a.rom_data_o, 32'hEE00_0000);
        fetch_a(32'h0, 1'b1, "t3_a0");
        fetch_a(32'h0, 1'b0, "t3_ce0_a0");
        fetch_a(32'h4, 1'b0, "t3_ce0_a4");

        // Restart mid-word, and start colliding with a byte.
        start_a();
        q = '{8'h55, 8'h66, 8'h77};
        send_a(q, 1'b0);
        bus_a.ld_start_i = 1'b1;
        bus_a.ld_valid_i = 1'b1;
        bus_a.ld_byte_i  = 8'h99;
        tick();
        bus_a.ld_start_i = 1'b0;
        bus_a.ld_valid_i = 1'b0;
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_a(q, 1'b1);
        model_load(q, 1'b1, 1024);
        check("t4_done", {31'h0, bus_a.ld_done_o}, 32'h1);
        check("t4_wcnt", {21'h0, bus_a.word_count_o}, 32'd1);
        fetch_a(32'h0, 1'b1, "t4_m0");
        check("t4_a0", bus_a.rom_data_o, 32'h1122_3344);
        fetch_a(32'h4, 1'b1, "t4_a4");

        // Overflow on the 4-word instance.
        bus_b.ld_start_i = 1'b1;
        tick();
        bus_b.ld_start_i = 1'b0;
        qb.delete();
        for (int i = 1; i <= 20; i++) begin
            qb.push_back(8'(i * 7 + 3));
            if (i > 16)
                check("t5_ready_low", {31'h0, bus_b.ld_ready_o}, 32'h0);
            bus_b.ld_valid_i = 1'b1;
            bus_b.ld_byte_i  = 8'(i * 7 + 3);
            tick();
            bus_b.ld_valid_i = 1'b0;
            if (i == 16) begin
                check("t5_err",  {31'h0, bus_b.ld_err_o}, 32'h1);
                check("t5_wcnt", {29'h0, bus_b.word_count_o}, 32'd4);
                check("t5_done", {31'h0, bus_b.ld_done_o}, 32'h1);
                check("t5_hold", {31'h0, bus_b.cpu_hold_o}, 32'h0);
            end
        end
        model_load(qb, 1'b0, 4);
        check("t5_model_err", {31'h0, bus_b.ld_err_o}, {31'h0, ref_err});
        check("t5_model_cnt", {29'h0, bus_b.word_count_o}, 32'(ref_cnt));
        for (int w = 0; w < 4; w++) begin
            bus_b.rom_ce_i   = 1'b1;
            bus_b.rom_addr_i = 32'(w * 4);
            #1;
            check($sformatf("t5_word%0d", w), bus_b.rom_data_o, ref_words[w]);
        end
        bus_b.rom_ce_i = 1'b0;

        // Reset in the middle of a load; reset also beats a start.
        start_a();
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_a(q, 1'b0);
        rst = 1'b0;
        bus_a.ld_start_i = 1'b1;
        tick();
        rst = 1'b1;
        bus_a.ld_start_i = 1'b0;
        bus_a.rom_ce_i   = 1'b1;
        bus_a.rom_addr_i = 32'h0;
        #1;
        check("t6_hold",  {31'h0, bus_a.cpu_hold_o}, 32'h1);
        check("t6_ready", {31'h0, bus_a.ld_ready_o}, 32'h0);
        check("t6_wcnt",  {21'h0, bus_a.word_count_o}, 32'h0);
        check("t6_data",  bus_a.rom_data_o, 32'h0);
        tick();
        check("t6_idle_stays", {31'h0, bus_a.ld_ready_o}, 32'h0);

        // Randomised fresh loads with random fetches.
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 60);
            q.delete();
            for (int j = 0; j < n; j++) q.push_back(8'($urandom_range(0, 255)));
            start_a();
            send_a(q, 1'b1);
            model_load(q, 1'b1, 1024);
            check($sformatf("rnd%0d_done", it), {31'h0, bus_a.ld_done_o}, 32'h1);
            check($sformatf("rnd%0d_wcnt", it), {21'h0, bus_a.word_count_o}, 32'(ref_cnt));
            check($sformatf("rnd%0d_err", it),  {31'h0, bus_a.ld_err_o}, 32'h0);
            for (int k = 0; k < 6; k++) begin
                addr = ($urandom & 32'hFFFF_F003) |
                       (32'($urandom_range(0, ref_cnt + 2)) << 2);
                fetch_a(addr, ($urandom_range(0, 4) != 0), $sformatf("rnd%0d_f%0d", it, k));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
